// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes and execution-stage state encoding shared by the
// ALU control decoder, alu_exec and alu_mul_serial.
// Optional feature macro: ALU_MUL_EN (enables code ALU_MUL and the BUSY state).
package alu_pkg;

    // 4-bit ALU control codes produced by the ALU control decoder
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    // Execution-stage state encoding (BUSY is only reachable with ALU_MUL_EN)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage : alu_pkg

// File: rtl/alu_mul_serial.sv
// alu_mul_serial: unsigned shift-add multiplier returning the low WIDTH bits
// of a*b. One step per cycle for WIDTH cycles after start; done pulses for one
// cycle together with the falling edge of busy, with product valid from then on.
// Only compiled when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_mul_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;

    // Load operands on start, then one shift-add step per cycle until the
    // step counter reaches its terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, regardless of statement order.
            r_done <= 1'b0;
            if (start) begin
                r_mcand  <= a;
                r_mplier <= b;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_busy   <= 1'b1;
            end else if (r_busy) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_acc;

endmodule : alu_mul_serial
`endif

// File: rtl/alu_exec.sv
// alu_exec: handshaked ALU execution stage. Captures {aluCtrl, srcA, srcB} on
// opValid&opReady, returns a registered result with zero/illegalOp flags and
// holds them until resValid&resReady.
// Optional feature macro: ALU_MUL_EN adds code ALU_MUL (unsigned multiply,
// WIDTH+1 cycles) via alu_mul_serial; without it that code is illegal.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             opValid,
    output logic             opReady,
    input  logic [3:0]       aluCtrl,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             resValid,
    input  logic             resReady,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegalOp
);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_illegal;

    logic [WIDTH-1:0] w_alu_res;
    logic             w_legal;
    logic             w_is_mul;
    logic             w_capture;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;

    // Decode the control code and compute the single-cycle result.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned, which would infer a latch.
        w_alu_res = '0;
        w_legal   = 1'b1;
        w_is_mul  = 1'b0;
        case (aluCtrl)
            ALU_AND: w_alu_res = srcA & srcB;
            ALU_OR:  w_alu_res = srcA | srcB;
            ALU_ADD: w_alu_res = srcA + srcB;
            ALU_SUB: w_alu_res = srcA - srcB;
`ifdef ALU_MUL_EN
            ALU_MUL: w_is_mul  = 1'b1;
`endif
            default: w_legal   = 1'b0;
        endcase
    end

    assign w_capture = opValid && (r_state == ST_IDLE);

`ifdef ALU_MUL_EN
    alu_mul_serial #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (w_capture && w_is_mul),
        .a      (srcA),
        .b      (srcB),
        .busy   (w_mul_busy),
        .done   (w_mul_done),
        .product(w_mul_product)
    );
`else
    // No multiplier: BUSY is never entered, so these are constant tie-offs.
    assign w_mul_busy    = 1'b0;
    assign w_mul_done    = 1'b0;
    assign w_mul_product = '0;
`endif

    // Handshake FSM: capture in IDLE, wait for the multiplier in BUSY, hold
    // the result in DONE until the consumer accepts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_capture) begin
                        if (w_is_mul) begin
                            r_illegal <= 1'b0;
                            r_state   <= ST_BUSY;
                        end else begin
                            // Illegal codes produce zero, so zero=1 follows.
                            r_result  <= w_alu_res;
                            r_zero    <= (w_alu_res == '0);
                            r_illegal <= ~w_legal;
                            r_state   <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_mul_done && !w_mul_busy) begin
                        r_result <= w_mul_product;
                        r_zero   <= (w_mul_product == '0);
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (resReady) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign opReady   = (r_state == ST_IDLE);
    assign resValid  = (r_state == ST_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegalOp = r_illegal;

endmodule : alu_exec

// File: tb/tb_alu_exec.sv
// tb_alu_exec: table-driven directed vectors, hand-written handshake/reset
// sequences, and randomized operations checked against an arithmetic model.
// Honours ALU_MUL_EN for the expected behaviour of code 4'b1000.
module tb_alu_exec;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         opValid;
    logic         opReady;
    logic [3:0]   aluCtrl;
    logic [W-1:0] srcA;
    logic [W-1:0] srcB;
    logic         resValid;
    logic         resReady;
    logic [W-1:0] result;
    logic         zero;
    logic         illegalOp;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]   c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         z;
        logic         ill;
        int           lat;
        int           stall;
    } vec_t;

    vec_t tbl[10];

    alu_exec #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .opValid  (opValid),
        .opReady  (opReady),
        .aluCtrl  (aluCtrl),
        .srcA     (srcA),
        .srcB     (srcB),
        .resValid (resValid),
        .resReady (resReady),
        .result   (result),
        .zero     (zero),
        .illegalOp(illegalOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: what the stage must return for one request.
    function automatic void ref_model(input logic [3:0] c, input logic [W-1:0] a,
                                      input logic [W-1:0] b, output logic [W-1:0] r,
                                      output logic ill, output int lat);
        ill = 1'b0;
        lat = 1;
        case (c)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: r = a + b;
            4'h6: r = a - b;
`ifdef ALU_MUL_EN
            4'h8: begin
                r   = a * b;
                lat = W + 1;
            end
`endif
            default: begin
                r   = '0;
                ill = 1'b1;
            end
        endcase
    endfunction

    // One full transaction, entered and left at #1 after a rising edge in IDLE.
    task automatic run_op(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er, input logic ez,
                          input logic ei, input int el, input int stall);
        int lat;
        check({tag, " opReady_idle"}, opReady, 1);
        aluCtrl = c;
        srcA    = a;
        srcB    = b;
        opValid = 1'b1;
        @(posedge clk); #1;
        opValid = 1'b0;
        aluCtrl = 4'($urandom);
        srcA    = $urandom;
        srcB    = $urandom;
        check({tag, " opReady_after_capture"}, opReady, 0);
        lat = 1;
        while (!resValid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, el);
        check({tag, " result"}, result, er);
        check({tag, " zero"}, zero, ez);
        check({tag, " illegalOp"}, illegalOp, ei);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, " held_result"}, result, er);
            check({tag, " held_opReady"}, opReady, 0);
        end
        resReady = 1'b1;
        @(posedge clk); #1;
        resReady = 1'b0;
        check({tag, " resValid_after_accept"}, resValid, 0);
    endtask

    initial begin
        logic [W-1:0] rr;
        logic         ri;
        int           rl;
        logic [3:0]   rc;
        logic [3:0]   pick[6];
        bit           seen;

        tbl[0] = '{4'b0010, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, 1, 0};
        tbl[1] = '{4'b0110, 32'h3,         32'h5,         32'hFFFF_FFFE, 1'b0, 1'b0, 1, 4};
        tbl[2] = '{4'b0000, 32'hF0F0,      32'hFF00,      32'hF000,      1'b0, 1'b0, 1, 0};
        tbl[3] = '{4'b0001, 32'hF0F0,      32'hFF00,      32'hFFF0,      1'b0, 1'b0, 1, 1};
        tbl[4] = '{4'b0111, 32'h1234,      32'h5678,      32'h0,         1'b1, 1'b1, 1, 0};
        tbl[5] = '{4'b0010, 32'h2,         32'h2,         32'h4,         1'b0, 1'b0, 1, 0};
`ifdef ALU_MUL_EN
        tbl[6] = '{4'b1000, 32'h7,         32'h6,         32'd42,        1'b0, 1'b0, 33, 2};
`else
        tbl[6] = '{4'b1000, 32'h7,         32'h6,         32'h0,         1'b1, 1'b1, 1, 2};
`endif
        tbl[7] = '{4'b0110, 32'h5,         32'h5,         32'h0,         1'b1, 1'b0, 1, 0};
        tbl[8] = '{4'b1111, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b1, 1, 0};
        tbl[9] = '{4'b0010, 32'h8000_0000, 32'h8000_0000, 32'h0,         1'b1, 1'b0, 1, 0};

        reset    = 1'b1;
        opValid  = 1'b0;
        resReady = 1'b0;
        aluCtrl  = '0;
        srcA     = '0;
        srcB     = '0;
        #12 reset = 1'b0;
        @(posedge clk); #1;

        check("reset result", result, 0);
        check("reset zero", zero, 0);
        check("reset resValid", resValid, 0);
        check("reset illegalOp", illegalOp, 0);
        check("reset opReady", opReady, 1);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].r,
                   tbl[i].z, tbl[i].ill, tbl[i].lat, tbl[i].stall);
        end

        // resReady while idle has no effect
        resReady = 1'b1;
        @(posedge clk); #1;
        check("idle resReady resValid", resValid, 0);
        check("idle resReady opReady", opReady, 1);
        resReady = 1'b0;

        // Back-to-back AND then OR with resReady held high: captures 2 cycles apart
        resReady = 1'b1;
        aluCtrl  = 4'b0000;
        srcA     = 32'hF0F0;
        srcB     = 32'hFF00;
        opValid  = 1'b1;
        @(posedge clk); #1;
        check("b2b and resValid", resValid, 1);
        check("b2b and result", result, 32'hF000);
        aluCtrl = 4'b0001;
        @(posedge clk); #1;
        check("b2b gap resValid", resValid, 0);
        check("b2b gap opReady", opReady, 1);
        @(posedge clk); #1;
        check("b2b or resValid", resValid, 1);
        check("b2b or result", result, 32'hFFF0);
        opValid = 1'b0;
        @(posedge clk); #1;
        resReady = 1'b0;
        check("b2b end opReady", opReady, 1);

        // Asynchronous reset while in DONE holding result 5
        aluCtrl = 4'b0010;
        srcA    = 32'd2;
        srcB    = 32'd3;
        opValid = 1'b1;
        @(posedge clk); #1;
        opValid = 1'b0;
        check("rstdone pre result", result, 5);
        #2 reset = 1'b1;
        #1;
        check("rstdone result", result, 0);
        check("rstdone resValid", resValid, 0);
        check("rstdone opReady", opReady, 1);
        check("rstdone zero", zero, 0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("rstdone after opReady", opReady, 1);

`ifdef ALU_MUL_EN
        // Reset during BUSY aborts the multiply
        aluCtrl = 4'b1000;
        srcA    = 32'd7;
        srcB    = 32'd6;
        opValid = 1'b1;
        @(posedge clk); #1;
        opValid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("busy opReady", opReady, 0);
        check("busy resValid", resValid, 0);
        reset = 1'b1;
        #1;
        check("rstbusy opReady", opReady, 1);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (resValid) seen = 1'b1;
        end
        check("rstbusy aborted", seen, 0);
`endif

        // Randomized operations against the model
        pick[0] = 4'h0;
        pick[1] = 4'h1;
        pick[2] = 4'h2;
        pick[3] = 4'h6;
        pick[4] = 4'h8;
        pick[5] = 4'h0;
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            if (i % 7 == 6) rc = 4'($urandom);
            else            rc = pick[$urandom_range(0, 4)];
            ra = $urandom;
            rb = (i % 5 == 0) ? ra : W'($urandom);
            ref_model(rc, ra, rb, rr, ri, rl);
            run_op($sformatf("rnd%0d", i), rc, ra, rb, rr, (rr == '0), ri, rl,
                   $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_alu_exec
